i2c_controller: RTL and testbench

//  Single-byte I2C bus controller (initiator) for exercising i2c_target.

---
 rtl/i2c_controller.sv | 187 ++++++++++++++++++
 tb/tb_i2c_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_controller.sv
// Single-byte I2C initiator: START, 7-bit address + R/W, one data byte, STOP.
// SCL is push-pull, SDA is open-drain (drives 0 or releases).
module i2c_controller #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic [7:0] rdata_o,
    output logic       scl_o,
    inout  wire        sda_io
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAack, StWdata, StWack, StRdata, StRnack, StStop, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rw_q, rw_d;
    logic            ack_err_q, ack_err_d;
    logic            tick, slot_end, sda_oe, sda_in;

    assign sda_io    = sda_oe ? 1'b0 : 1'bz;
    assign sda_in    = sda_io;
    assign ack_err_o = ack_err_q;
    assign rdata_o   = rdata_q;
    assign busy_o    = (state_q != StIdle);

    // Quarter tick; the divider only runs while a transfer is on the bus.
    assign tick     = (state_q != StIdle) && (state_q != StDone) && (div_q == DivW'(CLK_DIV - 1));
    assign slot_end = tick && (qtr_q == 2'd3);

    // State and datapath registers; reset releases both bus lines immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rw_q      <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rw_q      <= rw_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Next-state logic and bus line decode per state/quarter.
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rw_d      = rw_q;
        ack_err_d = ack_err_q;
        scl_o     = 1'b1;
        sda_oe    = 1'b0;
        done_o    = 1'b0;

        if ((state_q == StIdle) || (state_q == StDone)) begin
            div_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + DivW'(1);
        end
        if (tick) begin
            qtr_d = qtr_q + 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StStart;
                    shift_d   = {addr_i, rw_i};
                    rw_d      = rw_i;
                    wdata_d   = wdata_i;
                    ack_err_d = 1'b0;
                    qtr_d     = '0;
                    bit_d     = '0;
                end
            end
            StStart: begin
                // SDA falls with SCL high, then SCL drops.
                sda_oe = 1'b1;
                scl_o  = (qtr_q == 2'd0);
                if (tick && (qtr_q == 2'd1)) begin
                    state_d = StAddr;
                    qtr_d   = '0;
                end
            end
            StAddr: begin
                scl_o  = qtr_q[1];
                sda_oe = ~shift_q[7];
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StAack;
                end
            end
            StAack: begin
                scl_o = qtr_q[1];
                if (slot_end) begin
                    if (sda_in) begin
                        ack_err_d = 1'b1;
                        state_d   = StStop;
                    end else if (rw_q) begin
                        state_d = StRdata;
                    end else begin
                        state_d = StWdata;
                        shift_d = wdata_q;
                    end
                end
            end
            StWdata: begin
                scl_o  = qtr_q[1];
                sda_oe = ~shift_q[7];
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StWack;
                end
            end
            StWack: begin
                scl_o = qtr_q[1];
                if (slot_end) begin
                    if (sda_in) ack_err_d = 1'b1;
                    state_d = StStop;
                end
            end
            StRdata: begin
                scl_o = qtr_q[1];
                if (slot_end) begin
                    shift_d = {shift_q[6:0], sda_in};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rdata_d = {shift_q[6:0], sda_in};
                        state_d = StRnack;
                    end
                end
            end
            StRnack: begin
                // SDA stays released: NACK ends the single-byte read.
                scl_o = qtr_q[1];
                if (slot_end) state_d = StStop;
            end
            StStop: begin
                scl_o  = (qtr_q != 2'd0);
                sda_oe = (qtr_q != 2'd2);
                if (tick && (qtr_q == 2'd2)) begin
                    state_d = StDone;
                    qtr_d   = '0;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: behavioural I2C target on a pulled-up SDA line,
// expected bus bytes queued at stimulus time and popped as the target sees them.
module tb_i2c_controller;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [6:0]  TADDR   = 7'h70;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, ack_err, scl;
    logic [7:0] rdata;
    wire        sda;

    int n_checks = 0;
    int n_pass   = 0;

    // Target model state
    logic       tgt_low = 1'b0;
    logic       in_xfer = 1'b0;
    logic       sel = 1'b0;
    logic       is_rd = 1'b0;
    logic       nack_data = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] sh = 8'h00;
    logic [7:0] exp_b;
    int         bitn = 0;
    int         byte_idx = 0;
    int         stop_cnt = 0;
    int         busy_falls = 0;
    logic [7:0] sb[$];

    assign sda = tgt_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .rw_i     (rw),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .busy_o   (busy),
        .done_o   (done),
        .ack_err_o(ack_err),
        .rdata_o  (rdata),
        .scl_o    (scl),
        .sda_io   (sda)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge busy) busy_falls++;

    // START: SDA falls while SCL stays high (checked just after the edge).
    always @(negedge sda) begin
        #1;
        if (scl === 1'b1 && sda === 1'b0) begin
            in_xfer  = 1'b1;
            bitn     = 0;
            byte_idx = 0;
            sel      = 1'b0;
            tgt_low  = 1'b0;
        end
    end

    // STOP: SDA rises while SCL stays high.
    always @(posedge sda) begin
        #1;
        if (scl === 1'b1 && sda === 1'b1) begin
            if (in_xfer) stop_cnt++;
            in_xfer = 1'b0;
            tgt_low = 1'b0;
        end
    end

    always @(posedge scl) begin
        if (in_xfer) begin
            bitn++;
            if (bitn <= 8) sh = {sh[6:0], sda};
            else if (bitn == 9 && sel && is_rd && byte_idx == 1) check("rd_master_nack", sda, 1);
        end
    end

    always @(negedge scl) begin
        if (in_xfer) begin
            if (bitn == 8) begin
                exp_b = 'x;
                if (sb.size() > 0) exp_b = sb.pop_front();
                check("bus_byte", sh, exp_b);
                if (byte_idx == 0) begin
                    sel     = (sh[7:1] == TADDR);
                    is_rd   = sh[0];
                    tgt_low = sel;
                end else if (!is_rd) begin
                    tgt_low = sel && !nack_data;
                end else begin
                    tgt_low = 1'b0;
                end
            end else if (bitn == 9) begin
                bitn = 0;
                byte_idx++;
                tgt_low = 1'b0;
                if (sel && is_rd && byte_idx == 1) tgt_low = ~tx_byte[7];
            end else if (sel && is_rd && byte_idx == 1 && bitn >= 1 && bitn <= 7) begin
                tgt_low = ~tx_byte[7-bitn];
            end
        end
    end

    // One transaction; cycles counts from the cycle after accept (=1) to done_o.
    task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                           input logic poke, output int cycles);
        @(negedge clk);
        start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs after accept; they must not matter.
        rw = ~t_rw; addr = 7'h11; wdata = ~t_wdata;
        check("busy_after_accept", busy, 1);
        cycles = 1;
        while (!done && cycles < 2000) begin
            if (poke && cycles == 100) start = 1'b1;
            else start = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        check("done_seen", done, 1);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    int cyc, s0, f0;

    initial begin
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        @(negedge clk) rst_n = 1'b1;

        // 1: write 0xA5 to 0x70
        sb.push_back(8'hE0); sb.push_back(8'hA5); s0 = stop_cnt;
        run_txn(1'b0, 7'h70, 8'hA5, 1'b0, cyc);
        check("wr_latency", cyc, 309);
        check("wr_ack_err", ack_err, 0);
        check("wr_sb_empty", sb.size(), 0);
        check("wr_stop", stop_cnt - s0, 1);

        // 2: read 0x3C from 0x70
        tx_byte = 8'h3C;
        sb.push_back(8'hE1); sb.push_back(8'h3C); s0 = stop_cnt;
        run_txn(1'b1, 7'h70, 8'h00, 1'b0, cyc);
        check("rd_latency", cyc, 309);
        check("rd_rdata", rdata, 8'h3C);
        check("rd_ack_err", ack_err, 0);
        check("rd_sb_empty", sb.size(), 0);
        check("rd_stop", stop_cnt - s0, 1);

        // 3: address NACK
        sb.push_back(8'h22); s0 = stop_cnt;
        run_txn(1'b0, 7'h11, 8'h55, 1'b0, cyc);
        check("anack_latency", cyc, 165);
        check("anack_ack_err", ack_err, 1);
        check("anack_sb_empty", sb.size(), 0);
        check("anack_stop", stop_cnt - s0, 1);
        check("rdata_held", rdata, 8'h3C);

        // 4: write data NACK
        nack_data = 1'b1;
        sb.push_back(8'hE0); sb.push_back(8'h5A); s0 = stop_cnt;
        run_txn(1'b0, 7'h70, 8'h5A, 1'b0, cyc);
        check("wnack_latency", cyc, 309);
        check("wnack_ack_err", ack_err, 1);
        check("wnack_sb_empty", sb.size(), 0);
        check("wnack_stop", stop_cnt - s0, 1);
        nack_data = 1'b0;

        // 5: start while busy and in DONE cycle
        sb.push_back(8'hE0); sb.push_back(8'hC3); f0 = busy_falls;
        run_txn(1'b0, 7'h70, 8'hC3, 1'b1, cyc);
        check("poke_latency", cyc, 309);
        check("poke_ack_err", ack_err, 0);
        repeat (40) @(posedge clk);
        #1;
        check("poke_still_idle", busy, 0);
        check("poke_busy_falls", busy_falls - f0, 1);
        check("poke_sb_empty", sb.size(), 0);

        // 6: reset during a 0 bit of the address byte
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h70; wdata = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("pre_rst_sda_low", sda, 0);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        sb.push_back(8'hE0); sb.push_back(8'h96); s0 = stop_cnt;
        run_txn(1'b0, 7'h70, 8'h96, 1'b0, cyc);
        check("post_rst_latency", cyc, 309);
        check("post_rst_ack_err", ack_err, 0);
        check("post_rst_sb_empty", sb.size(), 0);
        check("post_rst_stop", stop_cnt - s0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
